// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding (common to RX and TX),
// parity type constants and the supported oversampling ratios.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Bit-timing counters for the UART receiver: an edge counter that walks
// 0..P-1 across each bit period and a data bit counter, plus the strobes the
// receiver needs (three majority sample points, vote-use point, end of bit).
module uart_rx_edge_bit_cnt
    import uart_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int PRESC_W = 6,
    localparam int BCW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               count_en,
    input  logic               bit_en,
    input  logic [PRESC_W-1:0] presc,
    output logic [BCW-1:0]     bit_cnt,
    output logic               smp_early,
    output logic               smp_mid,
    output logic               smp_late,
    output logic               sample_point,
    output logic               bit_done,
    output logic               last_bit
);

    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] half;

    assign half = presc >> 1;

    // Strobes decoded from the edge count; the vote is taken around mid-bit
    // and consumed two counts after the middle sample.
    always_comb begin
        smp_early    = (edge_cnt == half - 1'b1);
        smp_mid      = (edge_cnt == half);
        smp_late     = (edge_cnt == half + 1'b1);
        sample_point = (edge_cnt == half + 2'd2);
        bit_done     = (edge_cnt == presc - 1'b1);
        last_bit     = (bit_cnt == BCW'(WIDTH - 1));
    end

    // Edge counter: held at zero while the receiver stays idle, wraps per bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt <= '0;
        end else if (!count_en || bit_done) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // Data bit counter: only advances during the data phase, cleared otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt <= '0;
        end else if (!bit_en) begin
            bit_cnt <= '0;
        end else if (bit_done) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receive core. Synchronizes the serial line, majority-votes three
// samples around the middle of each bit, assembles an LSB-first word and
// checks start, parity and stop bits. Each frame ends in a single-cycle
// data_valid, par_err and/or stp_err pulse; P_DATA only updates on good frames.
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] Prescale,
    output logic [WIDTH-1:0]   P_DATA,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic exp_parity(input logic typ, input logic [WIDTH-1:0] d);
        exp_parity = ^d;
        case (typ)
            EVEN: exp_parity = ^d;
            ODD:  exp_parity = ~^d;
        endcase
    endfunction

    logic               sync_p0;
    logic               sync_p1;
    logic               rx_s;

    uart_state_e        state_q;
    uart_state_e        state_nx;
    logic               armed_q;
    logic               start_det;
    logic               decide;

    logic               par_en_q;
    logic               par_typ_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_cfg;

    logic               count_en;
    logic               bit_en;
    logic [BCW-1:0]     bit_cnt;
    logic               smp_early;
    logic               smp_mid;
    logic               smp_late;
    logic               sample_point;
    logic               bit_done;
    logic               last_bit;

    logic               smp_a_q;
    logic               smp_b_q;
    logic               vote_q;
    logic [WIDTH-1:0]   shreg_q;
    logic               par_bit_q;
    logic               stop_bad;
    logic               par_bad;

    assign rx_s = sync_p1;

    // Two-flop synchronizer for the asynchronous line; resets to idle (high).
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= RX_IN;
            sync_p1 <= sync_p0;
        end
    end

    // Unsupported ratios fall back to 8 so the bit timer never degenerates.
    always_comb begin
        if ((Prescale == PRESC_W'(PRESC_8)) || (Prescale == PRESC_W'(PRESC_16)) ||
            (Prescale == PRESC_W'(PRESC_32))) begin
            presc_cfg = Prescale;
        end else begin
            presc_cfg = PRESC_W'(PRESC_8);
        end
    end

    // Frame configuration is frozen at the start edge and held for the frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q  <= 1'b0;
            par_typ_q <= EVEN;
            presc_q   <= PRESC_W'(PRESC_8);
        end else if (start_det) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            presc_q   <= presc_cfg;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // FSM next state; the stop decision returns to IDLE without waiting out the bit.
    always_comb begin
        state_nx  = state_q;
        start_det = 1'b0;
        decide    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !rx_s) begin
                    start_det = 1'b1;
                    state_nx  = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_nx = vote_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done && last_bit) begin
                    state_nx = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_nx = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_point) begin
                    decide   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // The detect cycle in IDLE is edge count 0 of the start bit, so the
    // counter runs whenever the next state is not IDLE.
    always_comb begin
        count_en = (state_nx != ST_IDLE);
        bit_en   = (state_q == ST_DATA);
    end

    uart_rx_edge_bit_cnt #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) u_cnt (
        .CLK          (CLK),
        .RST          (RST),
        .count_en     (count_en),
        .bit_en       (bit_en),
        .presc        (presc_q),
        .bit_cnt      (bit_cnt),
        .smp_early    (smp_early),
        .smp_mid      (smp_mid),
        .smp_late     (smp_late),
        .sample_point (sample_point),
        .bit_done     (bit_done),
        .last_bit     (last_bit)
    );

    // A stop error disarms the receiver until the line is seen idle again,
    // so a held-low break reports only once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            armed_q <= 1'b1;
        end else if (decide && stop_bad) begin
            armed_q <= 1'b0;
        end else if (rx_s) begin
            armed_q <= 1'b1;
        end
    end

    // Majority sampler: two early samples held, vote registered on the third.
    always_ff @(posedge CLK) begin
        if (smp_early) begin
            smp_a_q <= rx_s;
        end
        if (smp_mid) begin
            smp_b_q <= rx_s;
        end
        if (smp_late) begin
            vote_q <= maj3(smp_a_q, smp_b_q, rx_s);
        end
    end

    // Word assembly (LSB first) and parity bit capture from the registered vote.
    always_ff @(posedge CLK) begin
        if ((state_q == ST_DATA) && sample_point) begin
            shreg_q[bit_cnt] <= vote_q;
        end
        if ((state_q == ST_PARITY) && sample_point) begin
            par_bit_q <= vote_q;
        end
    end

    // Frame checks evaluated in the stop-bit decision cycle.
    always_comb begin
        stop_bad = ~vote_q;
        par_bad  = par_en_q && (par_bit_q != exp_parity(par_typ_q, shreg_q));
    end

    // Output registers: single-cycle pulses; P_DATA only loads on a clean frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= decide && !stop_bad && !par_bad;
            par_err    <= decide && par_bad;
            stp_err    <= decide && stop_bad;
            if (decide && !stop_bad && !par_bad) begin
                P_DATA <= shreg_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames with hand-computed
// outcomes, then sequences for break, glitch, back-to-back and reset abort.
module tb_uart_rx;
    import uart_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(.WIDTH(8), .PRESC_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse log, sampled on the falling edge: cycle, {valid,par,stp}, P_DATA.
    int         ev_cyc[$];
    logic [2:0] ev_kind[$];
    logic [7:0] ev_data[$];
    always @(negedge CLK) begin
        if (data_valid || par_err || stp_err) begin
            ev_cyc.push_back(cyc);
            ev_kind.push_back({data_valid, par_err, stp_err});
            ev_data.push_back(P_DATA);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        ev_cyc.delete();
        ev_kind.delete();
        ev_data.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    // Drive one frame; t0 is the clock edge that first samples the start bit.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit pbit, input bit stop, input int gl_bit, input int gl_off,
                              output int t0);
        logic [10:0] fr;
        int nb;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = d;
        if (pen) begin
            fr[9] = pbit;
            fr[10] = stop;
            nb = 11;
        end else begin
            fr[9] = stop;
            nb = 10;
        end
        t0 = 0;
        for (int n = 0; n < nb; n++) begin
            for (int k = 0; k < p; k++) begin
                @(negedge CLK);
                if (n == 0 && k == 0) begin
                    Prescale = 6'(p);
                    PAR_EN = pen;
                    PAR_TYP = ptyp;
                    t0 = cyc + 1;
                end
                RX_IN = fr[n] ^ ((n == gl_bit) && (k == gl_off));
            end
        end
    endtask

    function automatic int dec_lat(input int p, input bit pen);
        int nstop;
        nstop = 1 + 8 + (pen ? 1 : 0);
        return 2 + nstop * p + p / 2 + 2;
    endfunction

    // First logged pulse checked for count, time, kind; P_DATA checked after.
    task automatic chk_single(input string nm, input int t0, input int lat, input logic [2:0] kind,
                              input logic [7:0] pdata);
        int tc;
        logic [2:0] kd;
        tc = (ev_cyc.size() > 0) ? ev_cyc[0] - t0 : -1;
        kd = (ev_kind.size() > 0) ? ev_kind[0] : 3'b000;
        chk({nm, "_count"}, 32'(ev_cyc.size()), 32'd1);
        chk({nm, "_time"}, 32'(tc), 32'(lat));
        chk({nm, "_kind"}, 32'(kd), 32'(kind));
        chk({nm, "_pdata"}, 32'(P_DATA), 32'(pdata));
    endtask

    typedef struct {
        logic [7:0] d;
        int         p;
        bit         pen;
        bit         ptyp;
        bit         pbit;
        bit         stop;
        logic [2:0] kind;
        logic [7:0] pdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int tdummy;
        int tc;
        int gap;
        logic [7:0] d0;
        logic [7:0] d1;

        vecs[0] = '{8'hA5, 8,  1'b1, EVEN, 1'b0, 1'b1, 3'b100, 8'hA5};
        vecs[1] = '{8'h66, 32, 1'b1, ODD,  1'b1, 1'b1, 3'b100, 8'h66};
        vecs[2] = '{8'hA5, 8,  1'b1, ODD,  1'b0, 1'b1, 3'b010, 8'h66};
        vecs[3] = '{8'hC3, 16, 1'b1, EVEN, 1'b0, 1'b0, 3'b001, 8'h66};
        vecs[4] = '{8'h81, 8,  1'b1, EVEN, 1'b1, 1'b0, 3'b011, 8'h66};
        vecs[5] = '{8'hFF, 32, 1'b0, EVEN, 1'b0, 1'b1, 3'b100, 8'hFF};
        vecs[6] = '{8'h00, 8,  1'b1, ODD,  1'b1, 1'b1, 3'b100, 8'h00};
        vecs[7] = '{8'h5A, 16, 1'b0, EVEN, 1'b0, 1'b1, 3'b100, 8'h5A};

        RST = 1'b1;
        RX_IN = 1'b1;
        PAR_EN = 1'b0;
        PAR_TYP = EVEN;
        Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        chk("rst_pdata", 32'(P_DATA), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_par", 32'(par_err), 32'h0);
        chk("rst_stp", 32'(stp_err), 32'h0);
        RST = 1'b0;
        idle(5);

        for (int i = 0; i < 8; i++) begin
            clear_log();
            send_frame(vecs[i].d, vecs[i].p, vecs[i].pen, vecs[i].ptyp, vecs[i].pbit,
                       vecs[i].stop, -1, 0, t0);
            idle(2 * vecs[i].p + 8);
            chk_single($sformatf("vec%0d", i), t0, dec_lat(vecs[i].p, vecs[i].pen),
                       vecs[i].kind, vecs[i].pdata);
        end

        // Stop error followed by a held-low line, then recovery.
        clear_log();
        send_frame(8'h3C, 16, 1'b0, EVEN, 1'b0, 1'b0, -1, 0, t0);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
        chk_single("break", t0, 156, 3'b001, 8'h5A);
        idle(20);
        clear_log();
        send_frame(8'h3C, 16, 1'b0, EVEN, 1'b0, 1'b1, -1, 0, t0);
        idle(40);
        chk_single("break_recover", t0, 156, 3'b100, 8'h3C);

        // Two-cycle low glitch on an idle line, then a frame with a mid-sample spike.
        clear_log();
        @(negedge CLK);
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        RX_IN = 1'b0;
        @(negedge CLK);
        RX_IN = 1'b0;
        idle(40);
        chk("glitch_count", 32'(ev_cyc.size()), 32'd0);
        chk("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
        clear_log();
        send_frame(8'h11, 8, 1'b0, EVEN, 1'b0, 1'b1, 4, 4, t0);
        idle(20);
        chk_single("spike", t0, 80, 3'b100, 8'h11);

        // Back-to-back frames with no idle gap.
        clear_log();
        send_frame(8'h3C, 16, 1'b0, EVEN, 1'b0, 1'b1, -1, 0, t1);
        send_frame(8'hC3, 16, 1'b0, EVEN, 1'b0, 1'b1, -1, 0, tdummy);
        idle(40);
        tc  = (ev_cyc.size() > 0) ? ev_cyc[0] - t1 : -1;
        gap = (ev_cyc.size() > 1) ? ev_cyc[1] - ev_cyc[0] : -1;
        d0  = (ev_data.size() > 0) ? ev_data[0] : 8'h00;
        d1  = (ev_data.size() > 1) ? ev_data[1] : 8'h00;
        chk("b2b_count", 32'(ev_cyc.size()), 32'd2);
        chk("b2b_time", 32'(tc), 32'd156);
        chk("b2b_gap", 32'(gap), 32'd160);
        chk("b2b_data0", 32'(d0), 32'h3C);
        chk("b2b_data1", 32'(d1), 32'hC3);
        chk("b2b_kind0", 32'((ev_kind.size() > 0) ? ev_kind[0] : 3'b000), 32'b100);
        chk("b2b_kind1", 32'((ev_kind.size() > 1) ? ev_kind[1] : 3'b000), 32'b100);

        // Reset pulse during data bit 4 aborts the frame.
        clear_log();
        fork
            send_frame(8'hF3, 8, 1'b0, EVEN, 1'b0, 1'b1, -1, 0, tdummy);
            begin
                repeat (45) @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                chk("abort_pdata", 32'(P_DATA), 32'h0);
                chk("abort_valid", 32'(data_valid), 32'h0);
                chk("abort_par", 32'(par_err), 32'h0);
                chk("abort_stp", 32'(stp_err), 32'h0);
                RST = 1'b0;
            end
        join
        idle(40);
        chk("abort_count", 32'(ev_cyc.size()), 32'd0);
        clear_log();
        send_frame(8'h5A, 8, 1'b0, EVEN, 1'b0, 1'b1, -1, 0, t0);
        idle(20);
        chk_single("after_abort", t0, 80, 3'b100, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receive core, the receive-side counterpart of the UART transmit path (serializer + parity calc). It oversamples the asynchronous `RX_IN` line by a programmable prescale, majority-votes each bit, and checks the start, parity and stop bits. It delivers one `WIDTH`-bit word per frame with a single-cycle valid or error pulse to the downstream register/FIFO logic.

## Interface
- `WIDTH`, 8: data bits per frame.
- `PRESC_W`, 6: width of `Prescale`.
- `CLK`  in  1  system clock.
- `RST`  in  1  synchronous, active-high reset.
- `RX_IN`  in  1  asynchronous serial line, idle high.
- `PAR_EN`  in  1  parity bit present when 1.
- `PAR_TYP`  in  1  0 = even (`EVEN`), 1 = odd (`ODD`).
- `Prescale`  in  PRESC_W  oversampling ratio P. Legal values are 8, 16 and 32; any other value gives undefined behaviour.
- `P_DATA`  out  WIDTH  last good word, LSB received first.
- `data_valid`  out  1  one-cycle pulse, good frame.
- `par_err`  out  1  one-cycle pulse, parity mismatch.
- `stp_err`  out  1  one-cycle pulse, stop bit sampled 0.

## Operation
- **Synchronizer:** `RX_IN` passes through a 2-FF synchronizer (reset value 1). The result is `rx_s`. All decoding uses `rx_s`.
- **Config capture:** `PAR_EN`, `PAR_TYP` and `Prescale` are captured in the cycle the start edge is detected. They are held for the whole frame.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: when armed and `rx_s`=0, go to START.
  - START: at end of bit, if the voted start bit is 1 (glitch), return to IDLE with no output pulse. Otherwise go to DATA.
  - DATA: shift the voted bit into bit `bit_cnt` (LSB first). After `WIDTH` bits, go to PARITY if `PAR_EN`, else STOP.
  - PARITY: store the voted bit, then go to STOP.
  - STOP: make the frame decision, then return to IDLE.
- **Sampling:** The edge counter runs 0..P-1 within each bit period. `rx_s` is sampled at edge counts P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, registered and used at edge count P/2+2.
- **Parity:** expected = `PAR_TYP` ? ~^data : ^data. `par_err` is raised when the received parity bit differs from expected. Parity is ignored when `PAR_EN`=0.
- **Frame decision:** made in STOP at edge count P/2+2, with these outputs in that cycle:
  - stop bit = 0: `stp_err`=1.
  - parity mismatch: `par_err`=1. Both errors may pulse together.
  - no error: `data_valid`=1 and `P_DATA` is loaded with the new word in the same cycle.
  - on any error: `data_valid` stays 0 and `P_DATA` holds its previous value.
- **Early return:** the FSM returns to IDLE in the next cycle and does not wait out the rest of the stop bit. A start edge arriving immediately after is therefore caught.
- **Re-arm after stop error:** the receiver disarms until `rx_s`=1 is seen. A held-low line (break) produces exactly one `stp_err`.
- **Reset:** `RST` mid-frame aborts the frame with no pulse. The FSM goes to IDLE (armed) and the counters go to 0.

## Timing
- Reset values: `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0, synchronizer flops = 1, FSM = IDLE, armed.
- Let c0 be the cycle in which IDLE sees `rx_s`=0. That is the cycle after `RX_IN` reaches the second synchronizer flop, so c0 = t+2 for `RX_IN` falling at cycle t.
- Bit n (start bit is n=0) occupies cycles c0+n·P .. c0+n·P+P-1. The edge count equals the cycle offset within the bit.
- Stop bit index N = 1+`WIDTH`+`PAR_EN`. The decision pulse occurs at c0+N·P+P/2+2.
  - Example: `WIDTH`=8, P=8, parity on gives t+88.
- Pulses are exactly one cycle wide. No two frame decisions can occur closer together than (N·P) cycles.
- A start edge is accepted in the cycle after the decision (IDLE, armed).

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding (shared with TX).
  - `EVEN`/`ODD` parity constants.
  - Legal prescale constants 8/16/32.
- Sub-module `uart_rx_edge_bit_cnt` contains:
  - edge counter (0..P-1) and bit counter.
  - `bit_done` and `sample_point` strobes.
- The top level holds the synchronizer, majority sampler, FSM, shift register, parity and stop checks, and output registers.

## Test plan
- P=8, even parity, 0xA5 (parity bit 0), stop 1 → `data_valid` pulse at t+88, `P_DATA`=0xA5, no errors.
- P=8, odd parity, 0xA5 with parity bit 0 → `par_err` pulse at t+88, no `data_valid`, `P_DATA` unchanged.
- P=16, `PAR_EN`=0, 0x3C with stop bit 0 → `stp_err` at t+2+144+10. Line then held low for 100 cycles → no further pulses. Line released high, then 0x3C sent → `data_valid`.
- P=8, `RX_IN` low for 2 cycles only → no pulses, FSM back in IDLE. Then 0x11 sent → received correctly. Also: a single-cycle inversion at sample point P/2 of data bit 3 → masked by majority vote.
- P=16, `PAR_EN`=0, 0x3C then 0xC3 back-to-back with no idle gap → two `data_valid` pulses exactly 160 cycles apart with correct data.
- `RST` pulsed during data bit 4 → all outputs 0 and no pulse for the aborted frame. A following 0x5A frame is received correctly.
